// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath and data memory.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       rf_we;
  logic       dm_we;
  logic       dm_re;
  logic [1:0] reg_dst;
  logic       alu_src;
  logic [1:0] wd_sel;
  logic [1:0] npc_sel;
  logic [1:0] ext_op;
  logic [2:0] alu_op;
  logic [2:0] state;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, rf_we, dm_we, dm_re, reg_dst, alu_src,
           wd_sel, npc_sel, ext_op, alu_op, state, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, rf_we, dm_we, dm_re, reg_dst, alu_src,
           wd_sel, npc_sel, ext_op, alu_op, state, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// Moore-style mux selects and write enables for the datapath.
module mc_ctrl (
  input  logic         clk,
  input  logic         reset,
  mc_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state_q, state_d, out_state;

  logic is_rtype, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_legal, is_short, is_alu;

  assign is_rtype = (bus.opcode == 6'h00);
  assign is_addu  = is_rtype && (bus.funct == 6'h21);
  assign is_subu  = is_rtype && (bus.funct == 6'h23);
  assign is_jr    = is_rtype && (bus.funct == 6'h08);
  assign is_nop   = is_rtype && (bus.funct == 6'h00);
  assign is_ori   = (bus.opcode == 6'h0D);
  assign is_lui   = (bus.opcode == 6'h0F);
  assign is_lw    = (bus.opcode == 6'h23);
  assign is_sw    = (bus.opcode == 6'h2B);
  assign is_beq   = (bus.opcode == 6'h04);
  assign is_j     = (bus.opcode == 6'h02);
  assign is_jal   = (bus.opcode == 6'h03);
  assign is_short = is_j | is_jal | is_jr | is_nop;
  assign is_alu   = is_addu | is_subu | is_ori | is_lui;
  assign is_legal = is_short | is_alu | is_lw | is_sw | is_beq;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: if (is_legal && !is_short) state_d = EXEC;
      EXEC: begin
        if (is_lw || is_sw) state_d = MEM;
        else if (is_alu)    state_d = WB;
      end
      MEM: begin
        if (is_lw)      state_d = bus.mem_ready ? WB : MEM;
        else if (is_sw) state_d = bus.mem_ready ? FETCH : MEM;
      end
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Reset shows FETCH values immediately so no strobe from an aborted state leaks out.
  assign out_state = reset ? FETCH : state_q;

  always_comb begin
    bus.pc_we   = 1'b0;
    bus.ir_we   = 1'b0;
    bus.rf_we   = 1'b0;
    bus.dm_we   = 1'b0;
    bus.dm_re   = 1'b0;
    bus.reg_dst = 2'b00;
    bus.alu_src = 1'b0;
    bus.wd_sel  = 2'b00;
    bus.npc_sel = 2'b00;
    bus.ext_op  = 2'b00;
    bus.alu_op  = 3'b000;
    bus.illegal = 1'b0;
    bus.state   = out_state;
    // ALU/extender controls stay put from EXEC through WB so address and result are stable.
    if (out_state == EXEC || out_state == MEM || out_state == WB) begin
      if (is_subu || is_beq) bus.alu_op = 3'b001;
      if (is_ori || is_lui)  bus.alu_op = 3'b010;
      if (is_ori || is_lui || is_lw || is_sw) bus.alu_src = 1'b1;
      if (is_lui)            bus.ext_op = 2'b10;
      if (is_lw || is_sw)    bus.ext_op = 2'b01;
    end
    case (out_state)
      FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
      end
      DECODE: begin
        if (is_j || is_jal) begin
          bus.pc_we   = 1'b1;
          bus.npc_sel = 2'b10;
        end
        if (is_jal) begin
          bus.rf_we   = 1'b1;
          bus.reg_dst = 2'b10;
          bus.wd_sel  = 2'b10;
        end
        if (is_jr) begin
          bus.pc_we   = 1'b1;
          bus.npc_sel = 2'b11;
        end
        if (!is_legal) bus.illegal = 1'b1;
      end
      EXEC: begin
        if (is_beq) begin
          bus.pc_we   = bus.zero;
          bus.npc_sel = 2'b01;
        end
      end
      MEM: begin
        bus.dm_re = is_lw;
        bus.dm_we = is_sw;
      end
      WB: begin
        bus.rf_we = 1'b1;
        if (is_addu || is_subu) bus.reg_dst = 2'b01;
        if (is_lw)              bus.wd_sel  = 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: stimulus pushes per-cycle expected
// outputs from an instruction-level model, a negedge monitor pops and compares.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mc_ctrl_if bus();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       dm_we;
    logic       dm_re;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] wd_sel;
    logic [1:0] npc_sel;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       illegal;
  } out_t;

  typedef enum int {
    K_ADDU, K_SUBU, K_JR, K_NOP, K_ORI, K_LUI,
    K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL
  } kind_e;

  out_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   return K_ADDU;
          6'h23:   return K_SUBU;
          6'h08:   return K_JR;
          6'h00:   return K_NOP;
          default: return K_ILL;
        endcase
      end
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // Expected outputs for one cycle, from the instruction's attributes and the phase it is in.
  function automatic out_t model(input int st, input kind_e k, input logic z);
    out_t o;
    o = '0;
    o.state = st[2:0];
    if (st == 0) begin
      o.ir_we = 1'b1;
      o.pc_we = 1'b1;
    end else if (st == 1) begin
      case (k)
        K_J:   begin o.pc_we = 1'b1; o.npc_sel = 2'b10; end
        K_JAL: begin
          o.pc_we = 1'b1; o.npc_sel = 2'b10;
          o.rf_we = 1'b1; o.reg_dst = 2'b10; o.wd_sel = 2'b10;
        end
        K_JR:  begin o.pc_we = 1'b1; o.npc_sel = 2'b11; end
        K_ILL: o.illegal = 1'b1;
        default: ;
      endcase
    end else begin
      case (k)
        K_SUBU, K_BEQ: o.alu_op = 3'b001;
        K_ORI:         begin o.alu_src = 1'b1; o.alu_op = 3'b010; end
        K_LUI:         begin o.alu_src = 1'b1; o.ext_op = 2'b10; o.alu_op = 3'b010; end
        K_LW, K_SW:    begin o.alu_src = 1'b1; o.ext_op = 2'b01; end
        default: ;
      endcase
      if (st == 2 && k == K_BEQ) begin
        o.pc_we   = z;
        o.npc_sel = 2'b01;
      end
      if (st == 3) begin
        o.dm_re = (k == K_LW);
        o.dm_we = (k == K_SW);
      end
      if (st == 4) begin
        o.rf_we   = 1'b1;
        o.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
        o.wd_sel  = (k == K_LW) ? 2'b01 : 2'b00;
      end
    end
    return o;
  endfunction

  task automatic checkOutput(input out_t e, input out_t a, input string t);
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", t, a, e);
    end
  endtask

  always @(negedge clk) begin
    out_t  e;
    out_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {bus.pc_we, bus.ir_we, bus.rf_we, bus.dm_we, bus.dm_re, bus.reg_dst,
           bus.alu_src, bus.wd_sel, bus.npc_sel, bus.ext_op, bus.alu_op,
           bus.state, bus.illegal};
      checkOutput(e, a, t);
    end
  end

  task automatic applyReset(input int cycles, input string name);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      reset         = 1'b1;
      bus.opcode    = 6'($urandom);
      bus.funct     = 6'($urandom);
      bus.zero      = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      exp_q.push_back(model(0, K_NOP, 1'b0));
      tag_q.push_back($sformatf("%s#%0d", name, c));
    end
  endtask

  // One instruction; abort=1 holds mem_ready low in MEM and then applies a 2-cycle reset.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int waits, input bit abort, input string name);
    kind_e k;
    int    phases[$];
    int    m;
    int    ph;
    k = classify(op, fn);
    phases.push_back(0);
    phases.push_back(1);
    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ}) phases.push_back(2);
    if (k == K_LW || k == K_SW) begin
      if (abort) phases.push_back(3);
      else for (int i = 0; i <= waits; i++) phases.push_back(3);
    end
    if (abort) begin
      phases.push_back(-1);
      phases.push_back(-1);
    end else if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW}) begin
      phases.push_back(4);
    end
    m = 0;
    for (int c = 0; c < phases.size(); c++) begin
      ph = phases[c];
      @(posedge clk); #1;
      reset      = (ph < 0);
      bus.opcode = op;
      bus.funct  = fn;
      bus.zero   = (ph == 2) ? z : 1'($urandom);
      if (ph == 3) begin
        bus.mem_ready = abort ? 1'b0 : (m == waits);
        m++;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      exp_q.push_back(model((ph < 0) ? 0 : ph, k, z));
      tag_q.push_back($sformatf("%s#%0d", name, c));
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         sel;
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    applyReset(3, "reset");
    applyStimulus(6'h00, 6'h21, 1'b0, 0, 1'b0, "addu");
    applyStimulus(6'h23, 6'h15, 1'b0, 3, 1'b0, "lw_wait3");
    applyStimulus(6'h04, 6'h2A, 1'b1, 0, 1'b0, "beq_taken");
    applyStimulus(6'h04, 6'h2A, 1'b0, 0, 1'b0, "beq_not_taken");
    applyStimulus(6'h03, 6'h11, 1'b0, 0, 1'b0, "jal");
    applyStimulus(6'h00, 6'h08, 1'b0, 0, 1'b0, "jr");
    applyStimulus(6'h3F, 6'h00, 1'b0, 0, 1'b0, "illegal_3f");
    applyStimulus(6'h2B, 6'h07, 1'b0, 2, 1'b0, "sw_wait2");
    applyStimulus(6'h23, 6'h01, 1'b0, 0, 1'b1, "lw_reset_abort");
    applyStimulus(6'h00, 6'h23, 1'b1, 0, 1'b0, "subu_after_reset");
    applyStimulus(6'h00, 6'h00, 1'b0, 0, 1'b0, "nop");
    applyStimulus(6'h0F, 6'h3C, 1'b0, 0, 1'b0, "lui");
    applyStimulus(6'h0D, 6'h21, 1'b0, 0, 1'b0, "ori");
    applyStimulus(6'h02, 6'h08, 1'b0, 0, 1'b0, "j");

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 13);
      fn  = 6'($urandom);
      case (sel)
        0:  begin op = 6'h00; fn = 6'h21; end
        1:  begin op = 6'h00; fn = 6'h23; end
        2:  begin op = 6'h00; fn = 6'h08; end
        3:  begin op = 6'h00; fn = 6'h00; end
        4:  op = 6'h0D;
        5:  op = 6'h0F;
        6:  op = 6'h23;
        7:  op = 6'h2B;
        8:  op = 6'h04;
        9:  op = 6'h02;
        10: op = 6'h03;
        11: op = 6'h00;
        default: op = 6'($urandom);
      endcase
      applyStimulus(op, fn, 1'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 19) == 0), $sformatf("rnd%0d_op%02h_fn%02h", n, op, fn));
    end

    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
